// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 scan-code sequencer: folds E0/F0 prefixes into 10-bit key events
// and queues them in a small first-word fall-through FIFO with sticky error flags.
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_Byte_Valid,
    input  logic [7:0]                    i_Byte,
    input  logic                          i_Pop,
    input  logic                          i_Clear_Flags,
    output logic                          o_Event_Valid,
    output logic [9:0]                    o_Event,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count,
    output logic                          o_Overflow,
    output logic                          o_Protocol_Error,
    output logic                          o_Busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] idle_cnt;
    logic          is_e0;
    logic          is_f0;
    logic          timeout;
    logic          push_req;
    logic          perr_set;
    logic [9:0]    push_ev;
    logic          do_pop;
    logic          do_push;
    logic          ovf_set;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign is_e0   = (i_Byte == 8'hE0);
    assign is_f0   = (i_Byte == 8'hF0);
    assign timeout = (state != IDLE) && !i_Byte_Valid && (idle_cnt == T_LAST);

    always_comb begin
        state_nx = state;
        push_req = 1'b0;
        perr_set = 1'b0;
        push_ev  = {2'b00, i_Byte};
        if (i_Byte_Valid) begin
            unique case (state)
                IDLE: begin
                    if (is_e0) begin
                        state_nx = EXT;
                    end else if (is_f0) begin
                        state_nx = BRK;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                EXT: begin
                    if (is_f0) begin
                        state_nx = EXT_BRK;
                    end else if (is_e0) begin
                        perr_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_ev  = {2'b10, i_Byte};
                        state_nx = IDLE;
                    end
                end
                BRK: begin
                    state_nx = IDLE;
                    if (is_e0 || is_f0) begin
                        perr_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_ev  = {2'b01, i_Byte};
                    end
                end
                EXT_BRK: begin
                    state_nx = IDLE;
                    if (is_e0 || is_f0) begin
                        perr_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_ev  = {2'b11, i_Byte};
                    end
                end
            endcase
        end else if (timeout) begin
            state_nx = IDLE;
            perr_set = 1'b1;
        end
    end

    // A pop frees a slot for a same-cycle push, so a full FIFO can stream.
    assign do_pop  = !i_rst && i_Pop && (count != '0);
    assign do_push = !i_rst && push_req && ((count != FULL) || do_pop);
    assign ovf_set = !i_rst && push_req && !do_push;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= IDLE;
            idle_cnt         <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            o_Overflow       <= 1'b0;
            o_Protocol_Error <= 1'b0;
        end else begin
            state <= state_nx;

            if (i_Byte_Valid || state_nx == IDLE) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (ovf_set) begin
                o_Overflow <= 1'b1;
            end else if (i_Clear_Flags) begin
                o_Overflow <= 1'b0;
            end

            if (perr_set) begin
                o_Protocol_Error <= 1'b1;
            end else if (i_Clear_Flags) begin
                o_Protocol_Error <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_ev;
        end
    end

    assign o_Event_Valid = (count != '0);
    assign o_Event       = o_Event_Valid ? mem[rd_ptr] : 10'h000;
    assign o_Count       = count;
    assign o_Busy        = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: directed scenarios plus random byte streams
// compared against a queue-based prefix/FIFO reference model.
module tb_ps2_key_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       bv;
    logic [7:0] b;
    logic       pop;
    logic       clr;
    logic       ev_valid;
    logic [9:0] ev;
    logic [2:0] cnt;
    logic       ovf;
    logic       perr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [9:0] q[$];
    bit         m_ext;
    bit         m_brk;
    bit         m_ovf;
    bit         m_perr;
    int         m_idle;

    ps2_key_sequencer #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_Byte_Valid    (bv),
        .i_Byte          (b),
        .i_Pop           (pop),
        .i_Clear_Flags   (clr),
        .o_Event_Valid   (ev_valid),
        .o_Event         (ev),
        .o_Count         (cnt),
        .o_Overflow      (ovf),
        .o_Protocol_Error(perr),
        .o_Busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_ext  = 0;
        m_brk  = 0;
        m_ovf  = 0;
        m_perr = 0;
        m_idle = 0;
    endtask

    // Prefix bits accumulate until a plain code byte consumes them.
    task automatic model_edge(input bit v, input logic [7:0] by,
                              input bit p, input bit c);
        bit         dp;
        bit         push;
        bit         perr_s;
        bit         ovf_s;
        logic [9:0] e;
        dp     = p && (q.size() > 0);
        push   = 0;
        perr_s = 0;
        ovf_s  = 0;
        e      = '0;
        if (v) begin
            m_idle = 0;
            if (by == 8'hE0) begin
                if (!m_ext && !m_brk) m_ext = 1;
                else if (m_ext && !m_brk) perr_s = 1;
                else begin perr_s = 1; m_ext = 0; m_brk = 0; end
            end else if (by == 8'hF0) begin
                if (!m_brk) m_brk = 1;
                else begin perr_s = 1; m_ext = 0; m_brk = 0; end
            end else begin
                push  = 1;
                e     = {m_ext, m_brk, by};
                m_ext = 0;
                m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            if (m_idle == TMO - 1) begin
                perr_s = 1; m_ext = 0; m_brk = 0; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        if (dp) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(e);
            else ovf_s = 1;
        end
        if (c) begin m_ovf = 0; m_perr = 0; end
        if (ovf_s) m_ovf = 1;
        if (perr_s) m_perr = 1;
    endtask

    task automatic step(input bit v, input logic [7:0] by,
                        input bit p, input bit c);
        bv  = v;
        b   = by;
        pop = p;
        clr = c;
        @(posedge clk);
        #1;
        model_edge(v, by, p, c);
        bv  = 0;
        pop = 0;
        clr = 0;
    endtask

    task automatic test_reset();
        rst = 1; bv = 0; b = 8'h00; pop = 0; clr = 0;
        model_reset();
        #1;
        checks++; if ({ev_valid, ev, cnt, ovf, perr, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {ev_valid, ev, cnt, ovf, perr, busy});
        end
        @(posedge clk); #1;
        bv = 1; b = 8'h1C;
        @(posedge clk); #1;
        rst = 0; bv = 0;
        checks++; if (cnt !== 3'd0) begin
            errors++; $display("FAIL reset_release_push got %0d want 0", cnt);
        end
    endtask

    task automatic test_make();
        checks++; if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL make_pre_valid got %b want 0", ev_valid);
        end
        step(1, 8'h1C, 0, 0);
        checks++; if (ev_valid !== 1'b1 || ev !== 10'h01C || cnt !== 3'd1) begin
            errors++; $display("FAIL make_event got v=%b e=%h c=%0d want v=1 e=01c c=1", ev_valid, ev, cnt);
        end
        step(0, 8'h00, 1, 0);
        checks++; if (ev_valid !== 1'b0 || cnt !== 3'd0) begin
            errors++; $display("FAIL make_pop got v=%b c=%0d want v=0 c=0", ev_valid, cnt);
        end
    endtask

    task automatic test_ext_break();
        step(1, 8'hE0, 0, 0);
        checks++; if (busy !== 1'b1 || cnt !== 3'd0) begin
            errors++; $display("FAIL extbrk_e0 got busy=%b c=%0d want busy=1 c=0", busy, cnt);
        end
        step(1, 8'hF0, 0, 0);
        checks++; if (busy !== 1'b1 || cnt !== 3'd0) begin
            errors++; $display("FAIL extbrk_f0 got busy=%b c=%0d want busy=1 c=0", busy, cnt);
        end
        step(1, 8'h75, 0, 0);
        checks++; if (ev !== 10'h375 || cnt !== 3'd1 || busy !== 1'b0 || perr !== 1'b0) begin
            errors++; $display("FAIL extbrk_event got e=%h c=%0d busy=%b perr=%b want 375 1 0 0", ev, cnt, busy, perr);
        end
        step(0, 8'h00, 1, 0);
    endtask

    task automatic test_double_break();
        step(1, 8'hF0, 0, 0);
        step(1, 8'hF0, 0, 0);
        checks++; if (perr !== 1'b1 || cnt !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL dblbrk_err got perr=%b c=%0d busy=%b want 1 0 0", perr, cnt, busy);
        end
        step(1, 8'h1C, 0, 0);
        checks++; if (ev !== 10'h01C || cnt !== 3'd1) begin
            errors++; $display("FAIL dblbrk_next got e=%h c=%0d want 01c 1", ev, cnt);
        end
        step(0, 8'h00, 1, 1);
        checks++; if (perr !== 1'b0 || cnt !== 3'd0) begin
            errors++; $display("FAIL dblbrk_clear got perr=%b c=%0d want 0 0", perr, cnt);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        logic [9:0] drain [4];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        drain = '{10'h01D, 10'h024, 10'h02D, 10'h01B};
        for (int i = 0; i < 5; i++) begin
            step(1, codes[i], 0, 0);
            if (i == 3) begin
                checks++; if (ovf !== 1'b0 || cnt !== 3'd4) begin
                    errors++; $display("FAIL ovf_fill got ovf=%b c=%0d want 0 4", ovf, cnt);
                end
            end
        end
        checks++; if (ovf !== 1'b1 || cnt !== 3'd4 || ev !== 10'h015) begin
            errors++; $display("FAIL ovf_drop got ovf=%b c=%0d e=%h want 1 4 015", ovf, cnt, ev);
        end
        step(1, 8'h1B, 1, 0);
        checks++; if (ovf !== 1'b1 || cnt !== 3'd4 || ev !== 10'h01D) begin
            errors++; $display("FAIL ovf_pushpop got ovf=%b c=%0d e=%h want 1 4 01d", ovf, cnt, ev);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ev !== drain[i]) begin
                errors++; $display("FAIL ovf_order%0d got %h want %h", i, ev, drain[i]);
            end
            step(0, 8'h00, 1, 0);
        end
        step(1, 8'h16, 1, 1);
        checks++; if (cnt !== 3'd1 || ev !== 10'h016 || ovf !== 1'b0) begin
            errors++; $display("FAIL empty_pushpop got c=%0d e=%h ovf=%b want 1 016 0", cnt, ev, ovf);
        end
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        checks++; if (cnt !== 3'd0 || ev_valid !== 1'b0) begin
            errors++; $display("FAIL empty_pop got c=%0d v=%b want 0 0", cnt, ev_valid);
        end
    endtask

    task automatic test_timeout();
        step(1, 8'hE0, 0, 0);
        for (int i = 0; i < TMO - 1; i++) step(0, 8'h00, 0, 0);
        checks++; if (busy !== 1'b1 || perr !== 1'b0) begin
            errors++; $display("FAIL tmo_early got busy=%b perr=%b want 1 0", busy, perr);
        end
        step(0, 8'h00, 0, 0);
        checks++; if (busy !== 1'b0 || perr !== 1'b1 || cnt !== 3'd0) begin
            errors++; $display("FAIL tmo_fire got busy=%b perr=%b c=%0d want 0 1 0", busy, perr, cnt);
        end
        step(0, 8'h00, 0, 1);
        checks++; if (perr !== 1'b0) begin
            errors++; $display("FAIL tmo_clear got %b want 0", perr);
        end
        step(1, 8'hE0, 0, 0);
        for (int i = 0; i < TMO - 1; i++) step(0, 8'h00, 0, 0);
        step(1, 8'h74, 0, 0);
        checks++; if (ev !== 10'h274 || perr !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_byte_wins got e=%h perr=%b busy=%b want 274 0 0", ev, perr, busy);
        end
        step(0, 8'h00, 1, 0);
    endtask

    task automatic test_async_reset();
        step(1, 8'h15, 0, 0);
        step(1, 8'h16, 0, 0);
        step(1, 8'hE0, 0, 0);
        checks++; if (cnt !== 3'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL areset_setup got c=%0d busy=%b want 2 1", cnt, busy);
        end
        #2 rst = 1;
        #1;
        checks++; if ({ev_valid, ev, cnt, ovf, perr, busy} !== '0) begin
            errors++; $display("FAIL areset_async got %h want 0", {ev_valid, ev, cnt, ovf, perr, busy});
        end
        #1 rst = 0;
        model_reset();
        step(1, 8'h1C, 0, 0);
        checks++; if (ev !== 10'h01C || cnt !== 3'd1) begin
            errors++; $display("FAIL areset_next got e=%h c=%0d want 01c 1", ev, cnt);
        end
        step(0, 8'h00, 1, 0);
    endtask

    task automatic test_random();
        logic [7:0] by;
        int         r;
        for (int i = 0; i < 800; i++) begin
            r  = $urandom_range(0, 9);
            by = (r < 3) ? 8'hE0 : (r < 5) ? 8'hF0 : 8'($urandom);
            step($urandom_range(0, 3) == 0, by,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
            checks++; if (cnt !== 3'(q.size()) || ev_valid !== (q.size() > 0)) begin
                errors++; $display("FAIL rnd_count[%0d] got c=%0d v=%b want %0d", i, cnt, ev_valid, q.size());
            end
            if (q.size() > 0) begin
                checks++; if (ev !== q[0]) begin
                    errors++; $display("FAIL rnd_head[%0d] got %h want %h", i, ev, q[0]);
                end
            end
            checks++; if (ovf !== m_ovf || perr !== m_perr || busy !== (m_ext | m_brk)) begin
                errors++; $display("FAIL rnd_flags[%0d] got o=%b p=%b b=%b want o=%b p=%b b=%b",
                                   i, ovf, perr, busy, m_ovf, m_perr, m_ext | m_brk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_double_break();
        test_overflow();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, 2..16.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, max idle cycles allowed inside a prefix sequence.
REQ-003 The block SHALL have port i_clk, input, 1, single clock; all logic on rising edge.
REQ-004 The block SHALL have port i_rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port i_Byte_Valid, input, 1, one-cycle strobe: i_Byte holds a new scan-code byte.
REQ-006 The block SHALL have port i_Byte, input, 8, scan-code byte from the PS/2 receiver.
REQ-007 The block SHALL have port i_Pop, input, 1, consumer removes head event this cycle.
REQ-008 The block SHALL have port i_Clear_Flags, input, 1, clears o_Overflow and o_Protocol_Error.
REQ-009 The block SHALL have port o_Event_Valid, output, 1, FIFO non-empty.
REQ-010 The block SHALL have port o_Event, output, 10, head event {ext, brk, code[7:0]}.
REQ-011 The block SHALL have port o_Count, output, log2(FIFO_DEPTH)+1, entries held.
REQ-012 The block SHALL have port o_Overflow, output, 1, sticky: event dropped on full FIFO.
REQ-013 The block SHALL have port o_Protocol_Error, output, 1, sticky: illegal prefix order or timeout.
REQ-014 The block SHALL have port o_Busy, output, 1, decoder is in a prefix state (not IDLE).

Function
REQ-015 The decoder SHALL have states IDLE, EXT, BRK and EXT_BRK, and SHALL act only on cycles where i_Byte_Valid=1.
REQ-016 In IDLE the decoder SHALL go to EXT on 0xE0, go to BRK on 0xF0, and on any other byte push {0,0,byte} and stay in IDLE.
REQ-017 In EXT the decoder SHALL go to EXT_BRK on 0xF0; on 0xE0 it SHALL set o_Protocol_Error and stay in EXT; on any other byte it SHALL push {1,0,byte} and go to IDLE.
REQ-018 In BRK, on 0xE0 or 0xF0 the decoder SHALL set o_Protocol_Error and go to IDLE with no push; on any other byte it SHALL push {0,1,byte} and go to IDLE.
REQ-019 In EXT_BRK, on 0xE0 or 0xF0 the decoder SHALL set o_Protocol_Error and go to IDLE with no push; on any other byte it SHALL push {1,1,byte} and go to IDLE.
REQ-020 A timeout counter SHALL reset on every i_Byte_Valid and on entry to IDLE, and SHALL count while not in IDLE.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES-1, the decoder SHALL go to IDLE and set o_Protocol_Error, with no push.
REQ-022 If a valid byte arrives in the same cycle as a timeout, the byte SHALL take priority and the timeout SHALL be ignored.
REQ-023 A push SHALL occur at the same clock edge that samples i_Byte_Valid=1.
REQ-024 The FIFO SHALL be first-word fall-through: o_Event_Valid and o_Event SHALL update the cycle after a push into an empty FIFO, giving 1 cycle latency.
REQ-025 Pop on an empty FIFO SHALL be ignored; o_Count SHALL NOT underflow.
REQ-026 A push on a full FIFO without a pop SHALL drop the event, set o_Overflow, and leave contents unchanged.
REQ-027 A push and pop in the same cycle on a full FIFO SHALL both complete, leave o_Count unchanged, and NOT set o_Overflow.
REQ-028 A push and pop in the same cycle on an empty FIFO SHALL ignore the pop, accept the push, and set o_Count=1.
REQ-029 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and o_Count SHALL range 0..FIFO_DEPTH.
REQ-030 If i_Clear_Flags and a new error or overflow event occur in the same cycle, the flag SHALL end the cycle set (set wins).
REQ-031 o_Busy SHALL be 1 exactly when the decoder state is not IDLE.

Reset
REQ-032 Asserting i_rst SHALL immediately, without a clock, force state=IDLE, timeout counter=0, FIFO pointers=0, o_Count=0, o_Event_Valid=0, o_Event=0, o_Overflow=0, o_Protocol_Error=0 and o_Busy=0.
REQ-033 A reset asserted mid-sequence (e.g. after 0xE0) SHALL discard the partial prefix, and the next byte SHALL be decoded from IDLE.
REQ-034 No push or pop SHALL occur on the clock edge at which i_rst is released while i_rst is still sampled high.

Verification
REQ-035 Bytes 0x1C -> o_Event=0x01C (10'h01C), o_Event_Valid=1 one cycle later, o_Count=1.
REQ-036 Bytes E0,F0,75 with i_Pop=0 -> single event 0x375, o_Busy high between bytes, o_Protocol_Error=0.
REQ-037 Bytes F0,F0 -> o_Protocol_Error=1 and no event pushed; next byte 0x1C -> event 0x01C.
REQ-038 With DEPTH=4, push 5 make codes 0x15,0x1D,0x24,0x2D,0x2C, no pop -> o_Count=4, o_Overflow=1, pops return 0x015,0x01D,0x024,0x02D; then a simultaneous push+pop while full -> o_Count stays 4 and o_Overflow is unchanged.
REQ-039 Byte E0 followed by no byte for TIMEOUT_CYCLES (set to 16 in the bench) -> o_Busy=0 and o_Protocol_Error=1 after 16 cycles; i_Clear_Flags -> 0.
REQ-040 Asynchronous i_rst pulse mid-cycle after E0 with 2 events queued -> all outputs 0 before the next clock edge; next byte 0x1C -> event 0x01C (not 0x21C).
